hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core. Owns every pipeline latch enable and flush, and the PC enable.

---
 rtl/hazard_ctrl_pkg.sv | 74 +++++++
 rtl/hazard_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: register numbers,
// sequencer states and the bundle of latch enables/flushes it drives.
package hazard_ctrl_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DRAIN,
    HALTED
  } hzState;

  // One bit per pipeline control output, in the order they appear on the port list.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  // Everything stopped: used for halt, drain and halted.
  localparam ctrl_t CTRL_STOP = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
  };

  // Data memory wait: front of the pipe frozen, MEM->WB keeps moving so WB
  // receives a bubble while the MEM instruction stays put.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
  };

  // Taken branch/jump in EX: squash the two younger instructions.
  localparam ctrl_t CTRL_REDIRECT = '{
    pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0
  };

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam ctrl_t CTRL_LOADUSE = '{
    pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0
  };

  // Fetch miss: hold PC, push a bubble into IF/ID, rest of the pipe advances.
  localparam ctrl_t CTRL_IMISS = '{
    pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0
  };

  localparam ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
  };

  // Load-use interlock: register $0 never creates a dependency.
  function automatic logic load_use(
    input logic     ex_load,
    input regbits_t ex_dst,
    input regbits_t rs,
    input regbits_t rt,
    input logic     uses_rt
  );
    return ex_load && (ex_dst != '0) &&
           ((ex_dst == rs) || (uses_rt && (ex_dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count up on i_inc, stop at the maximum value, clear has priority.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: drives every pipeline
// latch enable/flush and the PC enable, and counts PC-stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  hzState          r_state;
  hzState          w_next;
  logic [DW-1:0]   r_drain;
  logic            r_halted;
  logic            w_drain_load;
  logic            w_dmem_busy;
  logic            w_lu_hazard;
  logic            w_run_rules;
  logic            w_busy_eff;
  logic            w_stall_inc;
  ctrl_t           w_ctrl;

  assign w_dmem_busy = (mem_dREN | mem_dWEN) & ~dhit;
  assign w_lu_hazard = load_use(ex_dREN, ex_rt, id_rs, id_rt, id_uses_rt);

  // The dhit cycle that ends a data wait is decoded with the normal RUN
  // priority list, but with the memory treated as no longer busy.
  assign w_run_rules = (r_state == RUN) | ((r_state == DWAIT) & dhit);
  assign w_busy_eff  = (r_state == RUN) & w_dmem_busy;

  // Next-state and output decode from the current state and live inputs.
  always_comb begin
    w_ctrl       = CTRL_STOP;
    w_next       = r_state;
    w_drain_load = 1'b0;
    if (w_run_rules) begin
      w_next = RUN;
      if (wb_halt) begin
        w_ctrl       = CTRL_STOP;
        w_next       = DRAIN;
        w_drain_load = 1'b1;
      end else if (w_busy_eff) begin
        w_ctrl = CTRL_FREEZE;
        w_next = DWAIT;
      end else if (ex_redirect) begin
        w_ctrl = CTRL_REDIRECT;
      end else if (w_lu_hazard) begin
        w_ctrl = CTRL_LOADUSE;
      end else if (!ihit) begin
        w_ctrl = CTRL_IMISS;
      end else begin
        w_ctrl = CTRL_ADVANCE;
      end
    end else begin
      unique case (r_state)
        DWAIT: begin
          w_ctrl = CTRL_FREEZE;
          w_next = DWAIT;
        end
        DRAIN: begin
          w_ctrl = CTRL_STOP;
          w_next = (r_drain == '0) ? HALTED : DRAIN;
        end
        HALTED: begin
          w_ctrl = CTRL_STOP;
          w_next = HALTED;
        end
        default: begin
          w_ctrl = CTRL_STOP;
          w_next = RUN;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Drain countdown: loaded when halt reaches WB, counts down while draining.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_drain <= '0;
    end else if (w_drain_load) begin
      r_drain <= DW'(DRAIN_CYCLES - 1);
    end else if ((r_state == DRAIN) && (r_drain != '0)) begin
      r_drain <= r_drain - DW'(1);
    end
  end

  // Sticky halted flag, set on entry to HALTED.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_halted <= 1'b0;
    end else if (w_next == HALTED) begin
      r_halted <= 1'b1;
    end
  end

  assign w_stall_inc = ~w_ctrl.pc_en & (r_state != HALTED);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (CLK),
    .i_clear (RST),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  assign pc_en       = w_ctrl.pc_en;
  assign ifid_en     = w_ctrl.ifid_en;
  assign idex_en     = w_ctrl.idex_en;
  assign exmem_en    = w_ctrl.exmem_en;
  assign memwb_en    = w_ctrl.memwb_en;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_flush  = w_ctrl.idex_flush;
  assign exmem_flush = w_ctrl.exmem_flush;
  assign halted      = r_halted;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a stimulus process pushes the expected
// per-cycle response from a reference model; a monitor pops and compares.
module tb_hazard_ctrl;

  localparam int DRAIN = 3;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST, ihit, dhit, mem_dREN, mem_dWEN, id_uses_rt, ex_dREN, ex_redirect, wb_halt;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNT_W-1:0] stall_cnt;

  always #5 CLK = ~CLK;

  hazard_ctrl #(
    .DRAIN_CYCLES (DRAIN),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_dREN    (mem_dREN),
    .mem_dWEN    (mem_dWEN),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_dREN     (ex_dREN),
    .ex_rt       (ex_rt),
    .ex_redirect (ex_redirect),
    .wb_halt     (wb_halt),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    bit       rst, ihit, dhit, mr, mw, urt, exr, redir, halt;
    bit [4:0] rs, rt, ert;
  } stim_t;

  typedef struct {
    bit [7:0] ctl;
    bit       halted;
    int       cnt;
    int       cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model status: pending memory wait, cycle at which halt was
  // accepted (-1 if none), stall count, running cycle number.
  bit m_wait;
  int m_halt_at;
  int m_cnt;
  int m_cyc = 0;

  function automatic bit m_halted();
    return (m_halt_at >= 0) && (m_cyc >= m_halt_at + DRAIN + 1);
  endfunction

  // Control vector {pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_exmem}.
  function automatic bit [7:0] ref_ctl(input stim_t s);
    bit lu;
    lu = s.exr && (s.ert != 0) && ((s.ert == s.rs) || (s.urt && (s.ert == s.rt)));
    if (m_halt_at >= 0)                           return 8'b0000_0000;
    if (m_wait && !s.dhit)                        return 8'b0000_1000;
    if (s.halt)                                   return 8'b0000_0000;
    if (!m_wait && (s.mr || s.mw) && !s.dhit)     return 8'b0000_1000;
    if (s.redir)                                  return 8'b1111_1110;
    if (lu)                                       return 8'b0011_1010;
    if (!s.ihit)                                  return 8'b0111_1100;
    return 8'b1111_1000;
  endfunction

  function automatic void model_step(input stim_t s, input bit [7:0] ctl);
    if (s.rst) begin
      m_wait    = 1'b0;
      m_halt_at = -1;
      m_cnt     = 0;
    end else begin
      if (!ctl[7] && !m_halted() && (m_cnt < CMAX)) m_cnt++;
      if (m_halt_at < 0) begin
        if (m_wait) begin
          if (s.dhit) begin
            m_wait = 1'b0;
            if (s.halt) m_halt_at = m_cyc;
          end
        end else if (s.halt) begin
          m_halt_at = m_cyc;
        end else if ((s.mr || s.mw) && !s.dhit) begin
          m_wait = 1'b1;
        end
      end
    end
    m_cyc++;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s.rst = 0; s.ihit = 1; s.dhit = 0; s.mr = 0; s.mw = 0; s.urt = 0;
    s.exr = 0; s.redir = 0; s.halt = 0; s.rs = 0; s.rt = 0; s.ert = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = 0;
    s.ihit  = $urandom_range(0, 9) != 0;
    s.dhit  = $urandom_range(0, 2) != 0;
    s.mr    = $urandom_range(0, 3) == 0;
    s.mw    = $urandom_range(0, 5) == 0;
    s.urt   = $urandom_range(0, 1) != 0;
    s.exr   = $urandom_range(0, 2) == 0;
    s.redir = $urandom_range(0, 7) == 0;
    s.halt  = $urandom_range(0, 99) == 0;
    s.rs    = 5'($urandom_range(0, 7));
    s.rt    = 5'($urandom_range(0, 7));
    s.ert   = 5'($urandom_range(0, 7));
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    RST = s.rst; ihit = s.ihit; dhit = s.dhit; mem_dREN = s.mr; mem_dWEN = s.mw;
    id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt; ex_dREN = s.exr; ex_rt = s.ert;
    ex_redirect = s.redir; wb_halt = s.halt;
    e.ctl = 8'h00;
    if (!s.rst) begin
      e.ctl    = ref_ctl(s);
      e.halted = m_halted();
      e.cnt    = m_cnt;
      e.cyc    = m_cyc;
      exp_q.push_back(e);
    end
    model_step(s, e.ctl);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: the controller presents a response every non-reset cycle.
  always @(negedge CLK) begin
    exp_t     e;
    bit [7:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
      total++;
      if (got !== e.ctl) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%b want=%b", e.cyc, got, e.ctl);
      end
      total++;
      if (halted !== e.halted) begin
        bad++;
        $display("FAIL halted cyc=%0d got=%b want=%b", e.cyc, halted, e.halted);
      end
      total++;
      if (int'(stall_cnt) != e.cnt) begin
        bad++;
        $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1; step(s);
    end
    step(quiet());

    // Load-use on rs, then the load leaves EX.
    s = quiet(); s.exr = 1; s.ert = 8; s.rs = 8; step(s);
    step(quiet());
    // Load-use on rt only counts when rt is a source.
    s = quiet(); s.exr = 1; s.ert = 9; s.rt = 9; s.urt = 0; step(s);
    s.urt = 1; step(s);
    // Load into $0 never interlocks.
    s = quiet(); s.exr = 1; s.ert = 0; s.rs = 0; step(s);

    // Data wait with a redirect held in EX.
    s = quiet(); s.mr = 1; s.redir = 1;
    for (int i = 0; i < 4; i++) step(s);
    s.dhit = 1; step(s);
    step(quiet());

    // Redirect dominates load-use and fetch miss.
    s = quiet(); s.redir = 1; s.exr = 1; s.ert = 8; s.rs = 8; s.ihit = 0; step(s);
    s = quiet(); s.ihit = 0; step(s);

    // Halt and drain to halted, halt held in WB.
    s = quiet(); s.halt = 1;
    for (int i = 0; i < 8; i++) step(s);
    s.rst = 1; step(s);
    step(quiet());

    // Reset in the middle of the drain.
    s = quiet(); s.halt = 1;
    for (int i = 0; i < 2; i++) step(s);
    s.rst = 1; step(s);
    for (int i = 0; i < 3; i++) step(quiet());

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 800; i++) begin
      s = rand_stim();
      if ((m_halt_at >= 0) && (m_cyc > m_halt_at + DRAIN + 3)) s.rst = 1;
      if ($urandom_range(0, 199) == 0) s.rst = 1;
      step(s);
    end

    // Counter saturation with a long fetch miss.
    s = quiet(); s.rst = 1; step(s);
    s = quiet(); s.ihit = 0;
    for (int i = 0; i < CMAX + 8; i++) step(s);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
